pipe_sel_mux: RTL and testbench
===============================

Name: pipe_sel_mux

Overview:
- Parametrised N-to-1 operand-select mux followed by a pipeline register with valid, stall and flush control.
- Successor to the plain 32-bit 2:1 datapath mux.
- Used at stage boundaries, e.g. the ALU operand / forwarding select between ID/EX and EX/MEM, where the selected word must be registered and must obey pipeline hazard control.
- Adds:
  - arbitrary width and input count,
  - a registered output with bubble insertion,
  - hold-on-stall,
  - optional illegal-select detection.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden by users.
- RST_VAL, 0, value loaded into out_data on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select.
- in_valid  input  1  upstream stage holds a valid instruction.
- stall  input  1  hazard unit hold request; register keeps its contents.
- flush  input  1  hazard unit kill request; register becomes a bubble.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  registered copy of the select used (forwarding debug/trace).
- sel_err  output  1  present only with PIPE_SEL_MUX_CHECK_EN; see Optional Feature.
- err_cnt  output  8  present only with PIPE_SEL_MUX_CHECK_EN; see Optional Feature.

Behaviour:
- **Clock and reset:** one clock domain, clk. Reset is rst_n, asynchronous assert, active-low. Release is synchronous to clk, handled externally.
- **Reset values:** out_data = RST_VAL, out_valid = 0, out_sel = 0, sel_err = 0, err_cnt = 0.
- **Combinational select:** mux_out = input[sel] when sel < NUM_IN, else all zeros. The zero case is reachable only when NUM_IN is not a power of two.
- **Per-edge priority (highest first):**
  1. Reset.
  2. flush:
     - out_data <= RST_VAL, out_valid <= 0, out_sel <= 0.
     - flush overrides a simultaneous stall.
  3. stall:
     - all registers hold, including out_valid.
     - in_data, sel and in_valid are ignored.
  4. Otherwise load:
     - out_data <= mux_out, out_sel <= sel, out_valid <= in_valid.
- **Latency:** exactly 1 cycle from input to output when neither stall nor flush is asserted. There is no combinational path from any input to any output.
- **Invalid input:** when in_valid = 0, out_data still loads mux_out and out_valid = 0. Downstream qualifies data with out_valid.
- **Long stall:** a stall of any length preserves the word exactly. The first non-stalled edge loads the current inputs.
- **Flush then stall:** flush followed by stall holds the bubble (out_valid stays 0).
- **Reset mid-operation:** an asynchronous rst_n assertion immediately forces the reset values, regardless of stall or flush.
- **Parameter check:** NUM_IN < 2 or NUM_IN > 16 is rejected by an elaboration-time check.

Optional Feature:
- Macro: PIPE_SEL_MUX_CHECK_EN.
- With the macro defined:
  - A load edge with sel >= NUM_IN and in_valid = 1 sets sel_err = 1 for exactly one cycle.
  - The same edge increments err_cnt, which saturates at 8'hFF.
  - Stall and flush edges never set sel_err and never change err_cnt.
  - err_cnt clears only on reset.
  - For a power-of-two NUM_IN, sel_err stays 0 permanently.
- Without the macro:
  - sel_err and err_cnt ports and their logic are absent.
  - Out-of-range select still yields zero data silently.

Decomposition:
- Shared package pipe_mux_pkg holds:
  - the clog2-based select-width function,
  - the NUM_IN_MAX = 16 constant,
  - the ERR_CNT_W = 8 constant,
  - the pipe-control typedef (struct of stall, flush).
- One combinational sub-module mux_n_1, parametrised by WIDTH and NUM_IN. It performs the flattened-vector select with zero default.
- pipe_sel_mux instantiates mux_n_1 and adds the register, control and check logic.

Test Plan:
- **Reset:** WIDTH=32, NUM_IN=4, RST_VAL=32'hDEADBEEF; assert rst_n=0 mid-cycle -> out_data=DEADBEEF, out_valid=0, out_sel=0 immediately, without waiting for a clock edge.
- **Select sweep:** inputs 32'h11111111, 22222222, 33333333, 44444444; sel=0..3 with in_valid=1 on consecutive cycles -> out_data equals the matching input one cycle later; out_sel=0..3; out_valid=1.
- **Stall:** load 32'h33333333 (sel=2), then stall=1 for 5 cycles while sel and data change -> out_data stays 33333333, out_valid stays 1; first cycle after stall drops loads the new input.
- **Flush priority:** stall=1 and flush=1 on the same edge -> out_valid=0, out_data=RST_VAL; next edge with stall=1 only -> bubble held.
- **Illegal select, macro on:** NUM_IN=3 with PIPE_SEL_MUX_CHECK_EN, sel=3, in_valid=1 -> out_data=0, sel_err high for 1 cycle, err_cnt=1; repeated 300 times -> err_cnt=8'hFF.
- **Illegal select, masked:** same stimulus with in_valid=0 or stall=1 -> sel_err stays 0, err_cnt unchanged.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// Shared constants, select-width helper and hazard-control bundle
// for the registered operand-select mux.
package pipe_mux_pkg;

  localparam int NUM_IN_MAX = 16;
  localparam int ERR_CNT_W  = 8;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N-to-1 select over a flattened input vector;
// an out-of-range select yields all zeros.
module mux_n_1
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data
);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) out_data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_sel_mux.sv
// Operand-select mux with a stall/flush-controlled pipeline register.
// Define PIPE_SEL_MUX_CHECK_EN to add illegal-select detection.
module pipe_sel_mux
  import pipe_mux_pkg::*;
#(
  parameter int              WIDTH   = 32,
  parameter int              NUM_IN  = 4,
  localparam int             SEL_W   = sel_width(NUM_IN),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel
`ifdef PIPE_SEL_MUX_CHECK_EN
  ,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

  if (NUM_IN < 2 || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("pipe_sel_mux: NUM_IN must be in 2..16");
  end

  pipe_ctrl_t       ctrl;
  logic [WIDTH-1:0] mux_out;

  assign ctrl.stall = stall;
  assign ctrl.flush = flush;

  mux_n_1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (mux_out)
  );

  // flush wins over stall so a killed slot can never be held valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= RST_VAL;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (ctrl.flush) begin
      out_data  <= RST_VAL;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (!ctrl.stall) begin
      out_data  <= mux_out;
      out_valid <= in_valid;
      out_sel   <= sel;
    end
  end

`ifdef PIPE_SEL_MUX_CHECK_EN
  logic illegal;
  logic load;

  assign illegal = in_valid && (32'(sel) >= NUM_IN);
  assign load    = !ctrl.flush && !ctrl.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      sel_err <= load && illegal;
      if (load && illegal && err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux: a 4-input instance with a
// non-zero reset value and a 3-input instance for illegal selects.
module tb_pipe_sel_mux;
  import pipe_mux_pkg::*;

  localparam logic [31:0] RV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [127:0] d4;
  logic [1:0]  sel4;
  logic        v4, st4, fl4;
  logic [31:0] o4;
  logic        ov4;
  logic [1:0]  os4;
  logic [95:0] d3;
  logic [1:0]  sel3;
  logic        v3, st3, fl3;
  logic [31:0] o3;
  logic        ov3;
  logic [1:0]  os3;
`ifdef PIPE_SEL_MUX_CHECK_EN
  logic        err4, err3;
  logic [7:0]  cnt4, cnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_sel_mux #(
    .WIDTH(32), .NUM_IN(4), .RST_VAL(RV)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(sel4),
    .in_valid(v4), .stall(st4), .flush(fl4),
    .out_data(o4), .out_valid(ov4), .out_sel(os4)
`ifdef PIPE_SEL_MUX_CHECK_EN
    , .sel_err(err4), .err_cnt(cnt4)
`endif
  );

  pipe_sel_mux #(
    .WIDTH(32), .NUM_IN(3), .RST_VAL(32'h0)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .sel(sel3),
    .in_valid(v3), .stall(st3), .flush(fl3),
    .out_data(o3), .out_valid(ov3), .out_sel(os3)
`ifdef PIPE_SEL_MUX_CHECK_EN
    , .sel_err(err3), .err_cnt(cnt3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel4 = 2'd1; v4 = 1'b1;
    step();
    checks++;
    if (o4 !== 32'h22222222) begin
      errors++;
      $display("FAIL pre_reset_load got=%h exp=%h", o4, 32'h22222222);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o4 !== RV) begin
      errors++;
      $display("FAIL reset_data got=%h exp=%h", o4, RV);
    end
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", ov4);
    end
    checks++;
    if (os4 !== 2'd0) begin
      errors++;
      $display("FAIL reset_sel got=%0d exp=0", os4);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_select_sweep();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
    exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
    d4 = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
    v4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      step();
      checks++;
      if (o4 !== exp_w[i]) begin
        errors++;
        $display("FAIL sweep_data[%0d] got=%h exp=%h", i, o4, exp_w[i]);
      end
      checks++;
      if (os4 !== 2'(i)) begin
        errors++;
        $display("FAIL sweep_sel[%0d] got=%0d exp=%0d", i, os4, i);
      end
      checks++;
      if (ov4 !== 1'b1) begin
        errors++;
        $display("FAIL sweep_valid[%0d] got=%b exp=1", i, ov4);
      end
    end
`ifdef PIPE_SEL_MUX_CHECK_EN
    checks++;
    if (err4 !== 1'b0 || cnt4 !== 8'd0) begin
      errors++;
      $display("FAIL pow2_no_err got=%b/%0d exp=0/0", err4, cnt4);
    end
`endif
  endtask

  task automatic test_invalid_input();
    sel4 = 2'd1; v4 = 1'b0;
    step();
    checks++;
    if (o4 !== 32'h22222222 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL invalid_load got=%h/%b exp=22222222/0", o4, ov4);
    end
  endtask

  task automatic test_stall();
    sel4 = 2'd2; v4 = 1'b1;
    step();
    checks++;
    if (o4 !== 32'h33333333) begin
      errors++;
      $display("FAIL stall_preload got=%h exp=33333333", o4);
    end
    st4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel4 = 2'(i);
      v4 = i[0];
      d4 = {4{32'h0F0F0000 + 32'(i)}};
      step();
      checks++;
      if (o4 !== 32'h33333333 || ov4 !== 1'b1 || os4 !== 2'd2) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%h/%b/%0d exp=33333333/1/2",
                 i, o4, ov4, os4);
      end
    end
    st4 = 1'b0; sel4 = 2'd0; v4 = 1'b1;
    d4 = {32'h4, 32'h3, 32'h2, 32'hCAFEF00D};
    step();
    checks++;
    if (o4 !== 32'hCAFEF00D || ov4 !== 1'b1 || os4 !== 2'd0) begin
      errors++;
      $display("FAIL stall_release got=%h/%b/%0d exp=cafef00d/1/0",
               o4, ov4, os4);
    end
  endtask

  task automatic test_flush();
    sel4 = 2'd3; v4 = 1'b1;
    d4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    step();
    st4 = 1'b1; fl4 = 1'b1;
    step();
    checks++;
    if (o4 !== RV || ov4 !== 1'b0 || os4 !== 2'd0) begin
      errors++;
      $display("FAIL flush_prio got=%h/%b/%0d exp=deadbeef/0/0",
               o4, ov4, os4);
    end
    fl4 = 1'b0;
    step();
    checks++;
    if (o4 !== RV || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL flush_then_stall got=%h/%b exp=deadbeef/0", o4, ov4);
    end
    st4 = 1'b0;
    step();
    checks++;
    if (o4 !== 32'h44444444 || ov4 !== 1'b1 || os4 !== 2'd3) begin
      errors++;
      $display("FAIL flush_recover got=%h/%b/%0d exp=44444444/1/3",
               o4, ov4, os4);
    end
  endtask

  task automatic test_illegal_sel();
    d3 = {32'h33333333, 32'h22222222, 32'h11111111};
    sel3 = 2'd3; v3 = 1'b1;
    step();
    checks++;
    if (o3 !== 32'h0 || ov3 !== 1'b1) begin
      errors++;
      $display("FAIL illegal_zero got=%h/%b exp=0/1", o3, ov3);
    end
`ifdef PIPE_SEL_MUX_CHECK_EN
    checks++;
    if (err3 !== 1'b1 || cnt3 !== 8'd1) begin
      errors++;
      $display("FAIL illegal_flag got=%b/%0d exp=1/1", err3, cnt3);
    end
`endif
    sel3 = 2'd0;
    step();
    checks++;
    if (o3 !== 32'h11111111) begin
      errors++;
      $display("FAIL legal_after got=%h exp=11111111", o3);
    end
`ifdef PIPE_SEL_MUX_CHECK_EN
    checks++;
    if (err3 !== 1'b0 || cnt3 !== 8'd1) begin
      errors++;
      $display("FAIL err_one_cycle got=%b/%0d exp=0/1", err3, cnt3);
    end
    sel3 = 2'd3; v3 = 1'b0;
    step();
    checks++;
    if (err3 !== 1'b0 || cnt3 !== 8'd1) begin
      errors++;
      $display("FAIL mask_invalid got=%b/%0d exp=0/1", err3, cnt3);
    end
    v3 = 1'b1; st3 = 1'b1;
    step();
    checks++;
    if (err3 !== 1'b0 || cnt3 !== 8'd1) begin
      errors++;
      $display("FAIL mask_stall got=%b/%0d exp=0/1", err3, cnt3);
    end
    fl3 = 1'b1;
    step();
    checks++;
    if (err3 !== 1'b0 || cnt3 !== 8'd1) begin
      errors++;
      $display("FAIL mask_flush got=%b/%0d exp=0/1", err3, cnt3);
    end
    st3 = 1'b0; fl3 = 1'b0;
    repeat (299) step();
    checks++;
    if (err3 !== 1'b1 || cnt3 !== 8'hFF) begin
      errors++;
      $display("FAIL cnt_saturate got=%b/%h exp=1/ff", err3, cnt3);
    end
    sel3 = 2'd1;
    step();
    checks++;
    if (err3 !== 1'b0 || cnt3 !== 8'hFF) begin
      errors++;
      $display("FAIL cnt_hold got=%b/%h exp=0/ff", err3, cnt3);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    d4 = '0; sel4 = '0; v4 = 1'b0; st4 = 1'b0; fl4 = 1'b0;
    d3 = '0; sel3 = '0; v3 = 1'b0; st3 = 1'b0; fl3 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    test_reset();
    test_select_sweep();
    test_invalid_input();
    test_stall();
    test_flush();
    test_illegal_sel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
